// File: rtl/stb_gen_ctrl.sv
// stb_gen_ctrl: acquisition sequencer for one stb_gen instance.
// Resets stb_gen, runs period detection, confirms strobe lock by interval
// timing, retries on error/timeout/lock loss and reports status.
module stb_gen_ctrl #(
  parameter int unsigned T_CNT_WIDTH = 32,
  parameter int unsigned RST_CYC     = 4,
  parameter int unsigned DET_TMO     = 2**22,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned N_CONFIRM   = 2,
  parameter int unsigned TOL         = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   stb_arst_o,
  output logic                   stb_run_det_o,
  output logic                   stb_oe_o,
  input  logic                   stb_rdy_i,
  input  logic                   stb_err_i,
  input  logic [T_CNT_WIDTH-1:0] stb_period_i,
  input  logic                   stb_i,
  output logic                   busy_o,
  output logic                   lock_o,
  output logic                   fail_o,
  output logic [T_CNT_WIDTH-1:0] period_o,
  output logic [1:0]             retry_cnt_o
);

  localparam int unsigned CW = T_CNT_WIDTH + 1;
  localparam int unsigned PW = $clog2(N_CONFIRM + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_DETECT, S_CONFIRM, S_LOCKED, S_FAIL
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          pass_q, pass_d;
  logic                   armed_q, armed_d;
  logic                   stb_prev_q, stb_prev_d;
  logic [1:0]             retry_q, retry_d;
  logic [T_CNT_WIDTH-1:0] period_q, period_d;
  logic                   fail_q, fail_d;
  logic                   arst_q, arst_d;
  logic                   run_det_q, run_det_d;
  logic                   oe_q, oe_d;
  logic                   busy_q, busy_d;
  logic                   lock_q, lock_d;

  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] period_x2;
  logic [CW-1:0] tol_lo;
  logic [CW-1:0] tol_hi;
  logic          stb_edge;
  logic          in_tol;
  logic          retry_ev;

  // Shared counter helpers: saturating increment, watchdog limit, tolerance window
  always_comb begin
    cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    period_x2 = {period_q, 1'b0};
    tol_lo    = CW'(period_q) - CW'(TOL);
    tol_hi    = CW'(period_q) + CW'(TOL);
    in_tol    = (cnt_q >= tol_lo) && (cnt_q <= tol_hi);
    stb_edge  = stb_i && !stb_prev_q;
    stb_prev_d = stb_i;
  end

  // Next-state, counters and next registered output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    pass_d   = pass_q;
    armed_d  = armed_q;
    retry_d  = retry_q;
    period_d = period_q;
    fail_d   = fail_q;
    retry_ev = 1'b0;

    unique case (state_q)
      S_IDLE, S_FAIL: begin
        if (start_i && !abort_i) begin
          state_d  = S_RST;
          cnt_d    = '0;
          retry_d  = '0;
          fail_d   = 1'b0;
          period_d = '0;
        end
      end
      S_RST: begin
        if (cnt_q >= CW'(RST_CYC - 1)) begin
          state_d = S_DETECT;
          cnt_d   = '0;
        end
      end
      S_DETECT: begin
        if (stb_err_i) begin
          retry_ev = 1'b1;
        end else if (stb_rdy_i) begin
          if (CW'(stb_period_i) > CW'(2 * TOL)) begin
            period_d = stb_period_i;
            state_d  = S_CONFIRM;
            cnt_d    = '0;
            armed_d  = 1'b0;
            pass_d   = '0;
          end else begin
            retry_ev = 1'b1;
          end
        end else if (cnt_q >= CW'(DET_TMO - 1)) begin
          retry_ev = 1'b1;
        end
      end
      S_CONFIRM, S_LOCKED: begin
        if (stb_edge) begin
          cnt_d = CW'(1);
          if (!armed_q) begin
            armed_d = 1'b1;
          end else if (!in_tol) begin
            retry_ev = 1'b1;
          end else if (state_q == S_CONFIRM) begin
            if (pass_q == PW'(N_CONFIRM - 1)) state_d = S_LOCKED;
            else                              pass_d  = pass_q + PW'(1);
          end
        end else if (cnt_q > period_x2) begin
          retry_ev = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (retry_ev) begin
      if (retry_q < 2'(MAX_RETRY)) begin
        retry_d = retry_q + 2'd1;
        state_d = S_RST;
        cnt_d   = '0;
      end else begin
        state_d = S_FAIL;
      end
    end

    if (abort_i) state_d = S_IDLE;

    if (state_d == S_FAIL) fail_d = 1'b1;

    arst_d    = (state_d == S_IDLE) || (state_d == S_RST) || (state_d == S_FAIL);
    run_det_d = arst_d;
    oe_d      = (state_d == S_CONFIRM) || (state_d == S_LOCKED);
    busy_d    = (state_d == S_RST) || (state_d == S_DETECT) || (state_d == S_CONFIRM);
    lock_d    = (state_d == S_LOCKED);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pass_q     <= '0;
      armed_q    <= 1'b0;
      stb_prev_q <= 1'b0;
      retry_q    <= '0;
      period_q   <= '0;
      fail_q     <= 1'b0;
      arst_q     <= 1'b1;
      run_det_q  <= 1'b1;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      armed_q    <= armed_d;
      stb_prev_q <= stb_prev_d;
      retry_q    <= retry_d;
      period_q   <= period_d;
      fail_q     <= fail_d;
      arst_q     <= arst_d;
      run_det_q  <= run_det_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      lock_q     <= lock_d;
    end
  end

  assign stb_arst_o    = arst_q;
  assign stb_run_det_o = run_det_q;
  assign stb_oe_o      = oe_q;
  assign busy_o        = busy_q;
  assign lock_o        = lock_q;
  assign fail_o        = fail_q;
  assign period_o      = period_q;
  assign retry_cnt_o   = retry_q;

endmodule

// File: tb/tb_stb_gen_ctrl.sv
// Self-checking bench for stb_gen_ctrl: directed scenarios plus a randomized
// acquisition sequence checked against spec-level expectations.
`timescale 1ns/1ps
module tb_stb_gen_ctrl;

  localparam int unsigned TW        = 32;
  localparam int unsigned RST_CYC   = 4;
  localparam int unsigned DET_TMO   = 1000;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned N_CONFIRM = 2;
  localparam int unsigned TOL       = 4;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          stb_arst_o, stb_run_det_o, stb_oe_o;
  logic          stb_rdy_i = 1'b0;
  logic          stb_err_i = 1'b0;
  logic [TW-1:0] stb_period_i = '0;
  logic          stb_i = 1'b0;
  logic          busy_o, lock_o, fail_o;
  logic [TW-1:0] period_o;
  logic [1:0]    retry_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit tmo_flag = 1'b0;

  stb_gen_ctrl #(
    .T_CNT_WIDTH(TW), .RST_CYC(RST_CYC), .DET_TMO(DET_TMO),
    .MAX_RETRY(MAX_RETRY), .N_CONFIRM(N_CONFIRM), .TOL(TOL)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .start_i(start_i), .abort_i(abort_i),
    .stb_arst_o(stb_arst_o), .stb_run_det_o(stb_run_det_o), .stb_oe_o(stb_oe_o),
    .stb_rdy_i(stb_rdy_i), .stb_err_i(stb_err_i), .stb_period_i(stb_period_i),
    .stb_i(stb_i), .busy_o(busy_o), .lock_o(lock_o), .fail_o(fail_o),
    .period_o(period_o), .retry_cnt_o(retry_cnt_o)
  );

  always #4 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
  endtask

  // Rising edge on stb_i 'gap' cycles after the previous one
  task automatic strobe(input int gap);
    repeat (gap - 1) tick();
    stb_i = 1'b1; tick(); stb_i = 1'b0;
  endtask

  // Wait until stb_gen is released and detecting with output disabled
  task automatic wait_detect();
    int n = 0;
    while (!(stb_arst_o === 1'b0 && stb_run_det_o === 1'b0 && stb_oe_o === 1'b0) && n < 64) begin
      tick(); n++;
    end
    if (n >= 64) tmo_flag = 1'b1;
  endtask

  task automatic detect_rdy(input logic [TW-1:0] p);
    stb_rdy_i = 1'b1; stb_period_i = p; tick(); stb_rdy_i = 1'b0;
  endtask

  task automatic detect_err();
    stb_err_i = 1'b1; tick(); stb_err_i = 1'b0;
  endtask

  task automatic acquire(input int p);
    pulse_start(); wait_detect(); detect_rdy(TW'(p));
    strobe(5); strobe(p); strobe(p);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst_ni = 1'b0;
    repeat (3) tick();
    n_checks++; if (stb_arst_o !== 1'b1) begin n_fail++; $display("FAIL reset_arst: got %0b want 1", stb_arst_o); end
    n_checks++; if (stb_run_det_o !== 1'b1) begin n_fail++; $display("FAIL reset_run_det: got %0b want 1", stb_run_det_o); end
    n_checks++; if (stb_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %0b want 0", stb_oe_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    n_checks++; if (lock_o !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %0b want 0", lock_o); end
    n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %0b want 0", fail_o); end
    n_checks++; if (period_o !== '0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period_o); end
    n_checks++; if (retry_cnt_o !== 2'd0) begin n_fail++; $display("FAIL reset_retry: got %0d want 0", retry_cnt_o); end
    arst_ni = 1'b1;
    repeat (3) tick();
    n_checks++; if (stb_arst_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_hold: arst=%0b busy=%0b want 1/0", stb_arst_o, busy_o); end
  endtask

  task automatic test_nominal();
    int n = 0;
    tmo_flag = 1'b0;
    pulse_start();
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL nom_busy_start: got %0b want 1", busy_o); end
    while (stb_arst_o === 1'b1 && n < 20) begin n++; tick(); end
    n_checks++; if (n != RST_CYC) begin n_fail++; $display("FAIL nom_arst_len: got %0d want %0d", n, RST_CYC); end
    n_checks++; if (stb_run_det_o !== 1'b0 || stb_oe_o !== 1'b0) begin n_fail++; $display("FAIL nom_detect_out: run_det=%0b oe=%0b want 0/0", stb_run_det_o, stb_oe_o); end
    detect_rdy(TW'(1250));
    n_checks++; if (period_o !== TW'(1250)) begin n_fail++; $display("FAIL nom_period: got %0d want 1250", period_o); end
    n_checks++; if (stb_oe_o !== 1'b1 || lock_o !== 1'b0) begin n_fail++; $display("FAIL nom_confirm_out: oe=%0b lock=%0b want 1/0", stb_oe_o, lock_o); end
    strobe(5); strobe(1250);
    n_checks++; if (lock_o !== 1'b0) begin n_fail++; $display("FAIL nom_early_lock: got %0b want 0", lock_o); end
    strobe(1250);
    n_checks++; if (lock_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL nom_lock: lock=%0b busy=%0b want 1/0", lock_o, busy_o); end
    n_checks++; if (retry_cnt_o !== 2'd0) begin n_fail++; $display("FAIL nom_retry: got %0d want 0", retry_cnt_o); end
    pulse_start();
    n_checks++; if (lock_o !== 1'b1 || stb_arst_o !== 1'b0) begin n_fail++; $display("FAIL nom_start_ignored: lock=%0b arst=%0b want 1/0", lock_o, stb_arst_o); end
    pulse_abort();
  endtask

  task automatic test_loss_of_lock();
    int n = 0;
    acquire(1250);
    n_checks++; if (lock_o !== 1'b1) begin n_fail++; $display("FAIL lol_lock: got %0b want 1", lock_o); end
    while (lock_o === 1'b1 && n < 3000) begin tick(); n++; end
    n_checks++; if (n != 2 * 1250 + 1) begin n_fail++; $display("FAIL lol_drop_time: got %0d want %0d", n, 2 * 1250 + 1); end
    n_checks++; if (retry_cnt_o !== 2'd1 || stb_arst_o !== 1'b1 || stb_oe_o !== 1'b0) begin n_fail++; $display("FAIL lol_retry: retry=%0d arst=%0b oe=%0b want 1/1/0", retry_cnt_o, stb_arst_o, stb_oe_o); end
    n_checks++; if (period_o !== TW'(1250)) begin n_fail++; $display("FAIL lol_period_kept: got %0d want 1250", period_o); end
    pulse_abort();
  endtask

  task automatic test_det_err();
    tmo_flag = 1'b0;
    pulse_start(); wait_detect(); detect_err();
    n_checks++; if (retry_cnt_o !== 2'd1 || stb_arst_o !== 1'b1) begin n_fail++; $display("FAIL err_retry1: retry=%0d arst=%0b want 1/1", retry_cnt_o, stb_arst_o); end
    wait_detect();
    stb_err_i = 1'b1; stb_rdy_i = 1'b1; stb_period_i = TW'(250); tick();
    stb_err_i = 1'b0; stb_rdy_i = 1'b0;
    n_checks++; if (retry_cnt_o !== 2'd2 || period_o !== '0) begin n_fail++; $display("FAIL err_wins: retry=%0d period=%0d want 2/0", retry_cnt_o, period_o); end
    wait_detect(); detect_rdy(TW'(250));
    strobe(5); strobe(250); strobe(250);
    n_checks++; if (lock_o !== 1'b1 || retry_cnt_o !== 2'd2 || period_o !== TW'(250)) begin n_fail++; $display("FAIL err_final: lock=%0b retry=%0d period=%0d want 1/2/250", lock_o, retry_cnt_o, period_o); end
    n_checks++; if (tmo_flag) begin n_fail++; $display("FAIL err_wait_detect: got timeout want none"); end
    pulse_abort();
  endtask

  task automatic test_tolerance();
    tmo_flag = 1'b0;
    pulse_start(); wait_detect(); detect_rdy(TW'(1250));
    strobe(5); strobe(1250 + TOL); strobe(1250 - TOL);
    n_checks++; if (lock_o !== 1'b1) begin n_fail++; $display("FAIL tol_edge_lock: got %0b want 1", lock_o); end
    pulse_abort();
    pulse_start(); wait_detect(); detect_rdy(TW'(1250));
    strobe(5); strobe(1250 + TOL + 1);
    n_checks++; if (lock_o !== 1'b0 || retry_cnt_o !== 2'd1 || stb_oe_o !== 1'b0) begin n_fail++; $display("FAIL tol_high_retry: lock=%0b retry=%0d oe=%0b want 0/1/0", lock_o, retry_cnt_o, stb_oe_o); end
    wait_detect(); detect_rdy(TW'(1250));
    strobe(5); strobe(1250 - TOL - 1);
    n_checks++; if (retry_cnt_o !== 2'd2 || stb_arst_o !== 1'b1) begin n_fail++; $display("FAIL tol_low_retry: retry=%0d arst=%0b want 2/1", retry_cnt_o, stb_arst_o); end
    n_checks++; if (tmo_flag) begin n_fail++; $display("FAIL tol_wait_detect: got timeout want none"); end
    pulse_abort();
  endtask

  task automatic test_timeout();
    int n = 0;
    int exp_n = (MAX_RETRY + 1) * (RST_CYC + DET_TMO);
    pulse_start();
    while (fail_o !== 1'b1 && n < 6000) begin tick(); n++; end
    n_checks++; if (n < exp_n - 8 || n > exp_n + 8) begin n_fail++; $display("FAIL tmo_time: got %0d want %0d +-8", n, exp_n); end
    n_checks++; if (busy_o !== 1'b0 || retry_cnt_o !== 2'(MAX_RETRY)) begin n_fail++; $display("FAIL tmo_status: busy=%0b retry=%0d want 0/%0d", busy_o, retry_cnt_o, MAX_RETRY); end
    n_checks++; if (stb_arst_o !== 1'b1 || stb_oe_o !== 1'b0 || lock_o !== 1'b0) begin n_fail++; $display("FAIL tmo_outputs: arst=%0b oe=%0b lock=%0b want 1/0/0", stb_arst_o, stb_oe_o, lock_o); end
    repeat (20) tick();
    n_checks++; if (fail_o !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %0b want 1", fail_o); end
    pulse_abort();
    n_checks++; if (fail_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL tmo_abort_keep: fail=%0b busy=%0b want 1/0", fail_o, busy_o); end
    pulse_start();
    n_checks++; if (fail_o !== 1'b0 || retry_cnt_o !== 2'd0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL tmo_restart: fail=%0b retry=%0d busy=%0b want 0/0/1", fail_o, retry_cnt_o, busy_o); end
    pulse_abort();
  endtask

  task automatic test_abort();
    tmo_flag = 1'b0;
    pulse_start(); wait_detect();
    pulse_abort();
    n_checks++; if (stb_arst_o !== 1'b1 || busy_o !== 1'b0 || stb_run_det_o !== 1'b1) begin n_fail++; $display("FAIL abort_detect: arst=%0b busy=%0b run_det=%0b want 1/0/1", stb_arst_o, busy_o, stb_run_det_o); end
    start_i = 1'b1; abort_i = 1'b1; tick(); start_i = 1'b0; abort_i = 1'b0;
    repeat (5) tick();
    n_checks++; if (stb_arst_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_wins: arst=%0b busy=%0b want 1/0", stb_arst_o, busy_o); end
    n_checks++; if (tmo_flag) begin n_fail++; $display("FAIL abort_wait_detect: got timeout want none"); end
  endtask

  task automatic test_async_reset();
    acquire(1250);
    n_checks++; if (lock_o !== 1'b1) begin n_fail++; $display("FAIL ares_pre_lock: got %0b want 1", lock_o); end
    @(posedge clk_i); #2; arst_ni = 1'b0; #1;
    n_checks++; if (stb_arst_o !== 1'b1 || stb_run_det_o !== 1'b1 || stb_oe_o !== 1'b0) begin n_fail++; $display("FAIL ares_stb_out: arst=%0b run_det=%0b oe=%0b want 1/1/0", stb_arst_o, stb_run_det_o, stb_oe_o); end
    n_checks++; if (busy_o !== 1'b0 || lock_o !== 1'b0 || fail_o !== 1'b0) begin n_fail++; $display("FAIL ares_status: busy=%0b lock=%0b fail=%0b want 0/0/0", busy_o, lock_o, fail_o); end
    n_checks++; if (period_o !== '0 || retry_cnt_o !== 2'd0) begin n_fail++; $display("FAIL ares_regs: period=%0d retry=%0d want 0/0", period_o, retry_cnt_o); end
    @(negedge clk_i); arst_ni = 1'b1;
    tick();
  endtask

  // Random detection faults and strobe jitter versus spec-level rules
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int p, k, d1, d2, exp_retry;
      bit exp_lock;
      tmo_flag  = 1'b0;
      p         = (it == 0) ? int'(2 * TOL + 1) : int'($urandom_range(400, 10));
      k         = int'($urandom_range(2, 0));
      d1        = int'($urandom_range(12, 0)) - 6;
      d2        = int'($urandom_range(12, 0)) - 6;
      exp_retry = 0;
      pulse_abort(); pulse_start();
      for (int j = 0; j < k; j++) begin
        wait_detect();
        if ($urandom_range(1, 0) == 1) detect_err();
        else detect_rdy(TW'($urandom_range(2 * TOL, 0)));
        exp_retry++;
      end
      wait_detect(); detect_rdy(TW'(p));
      n_checks++; if (period_o !== TW'(p) || stb_oe_o !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_confirm: period=%0d oe=%0b want %0d/1", it, period_o, stb_oe_o, p); end
      strobe(5); strobe(p + d1);
      if (d1 < -int'(TOL) || d1 > int'(TOL)) begin
        exp_retry++; exp_lock = 1'b0;
      end else begin
        strobe(p + d2);
        if (d2 < -int'(TOL) || d2 > int'(TOL)) begin exp_retry++; exp_lock = 1'b0; end
        else exp_lock = 1'b1;
      end
      n_checks++; if (lock_o !== exp_lock || retry_cnt_o !== 2'(exp_retry)) begin n_fail++; $display("FAIL rnd%0d_result: p=%0d d1=%0d d2=%0d lock=%0b retry=%0d want %0b/%0d", it, p, d1, d2, lock_o, retry_cnt_o, exp_lock, exp_retry); end
      n_checks++; if (period_o !== TW'(p) || tmo_flag) begin n_fail++; $display("FAIL rnd%0d_period: got %0d tmo=%0b want %0d/0", it, period_o, tmo_flag, p); end
    end
    pulse_abort();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_loss_of_lock();
    test_det_err();
    test_tolerance();
    test_timeout();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stb_gen_ctrl.md
Name: stb_gen_ctrl

Overview:
Sequencer for one stb_gen instance. On a host start command it resets stb_gen, runs period detection, and checks the reported period. It then enables strobe output and confirms lock by timing successive strobes. It retries on error, timeout or loss of lock, and reports final status and the locked period to the measure-unit register block.

Parameters:
T_CNT_WIDTH, 32, width of period values (clk_i cycles)
RST_CYC, 4, cycles stb_arst_o is held high per attempt
DET_TMO, 2**22, max cycles in DETECT before timeout
MAX_RETRY, 3, retries after first attempt before FAIL
N_CONFIRM, 2, consecutive in-tolerance strobe intervals needed for lock
TOL, 4, allowed |interval - period| in cycles

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous reset, active low
start_i  in  1  1-cycle pulse: begin acquisition
abort_i  in  1  1-cycle pulse: stop, return to IDLE
stb_arst_o  out  1  reset to stb_gen (active high)
stb_run_det_o  out  1  high holds stb_gen detect-idle; low = detection running
stb_oe_o  out  1  stb_gen output enable
stb_rdy_i  in  1  stb_gen period valid
stb_err_i  in  1  stb_gen detection error
stb_period_i  in  T_CNT_WIDTH  measured period, cycles
stb_i  in  1  stb_gen strobe (synchronous to clk_i)
busy_o  out  1  acquisition in progress
lock_o  out  1  strobe locked
fail_o  out  1  sticky failure until next start
period_o  out  T_CNT_WIDTH  latched period
retry_cnt_o  out  2  retries consumed

Behaviour:
- Reset values: stb_arst_o=1, stb_run_det_o=1, stb_oe_o=0, busy_o=0, lock_o=0, fail_o=0, period_o=0, retry_cnt_o=0; FSM=IDLE.
- States: IDLE, RST, DETECT, CONFIRM, LOCKED, FAIL.
- IDLE: stb_arst_o=1, run_det=1, oe=0. start_i -> RST; clears retry_cnt_o, fail_o, period_o.
- RST: stb_arst_o=1, run_det=1 for exactly RST_CYC cycles, then stb_arst_o=0 and -> DETECT. busy_o=1 from the cycle after start_i until LOCKED, FAIL or IDLE.
- DETECT: run_det=0, oe=0. Timeout counter starts at 0 on entry.
  - stb_rdy_i=1 with stb_period_i > 2*TOL: latch period_o -> CONFIRM.
  - stb_err_i=1, or rdy with period <= 2*TOL, or counter reaches DET_TMO: retry event.
  - If rdy and err assert in the same cycle, err wins.
- CONFIRM: oe=1, run_det=0.
  - An interval counter restarts on each stb_i rising edge. The first edge only arms the counter.
  - Each subsequent edge compares the count to period_o ± TOL, inclusive.
  - N_CONFIRM consecutive passes -> LOCKED.
  - A failing interval, or the counter exceeding 2*period_o with no edge, is a retry event.
- LOCKED: lock_o=1, oe=1. The interval watchdog keeps running.
  - The counter exceeding 2*period_o, or an interval outside tolerance, drops lock_o the next cycle and is a retry event.
- Retry event:
  - If retry_cnt_o < MAX_RETRY: increment it, go to RST, oe=0 the next cycle, period_o kept until overwritten.
  - Else: go to FAIL.
- FAIL: fail_o=1 (sticky), busy_o=0, lock_o=0, stb_arst_o=1, oe=0. start_i -> RST as from IDLE.
- abort_i from any state -> IDLE the next cycle, with IDLE output values. lock_o/busy_o clear and fail_o is preserved. If start_i and abort_i arrive in the same cycle, abort wins.
- start_i in any state other than IDLE/FAIL is ignored.
- Counters are T_CNT_WIDTH+1 bits and saturate; 2*period_o is computed without overflow.
- Asynchronous reset mid-operation returns everything to reset values immediately.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Nominal: start with stb_gen driven by 1250-cycle period (10 µs at 8 ns clock) -> stb_arst_o high 4 cycles, DETECT, period_o=1250, after 3 strobes lock_o=1, busy_o=0, retry_cnt_o=0.
- Detection error: stb_err_i pulsed on first two attempts, third gives rdy with period 250 -> retry_cnt_o=2, period_o=250, lock_o=1.
- Timeout exhaustion: DET_TMO=1000, stb_rdy_i/stb_err_i never assert -> 4 attempts each ~1004 cycles, then fail_o=1, busy_o=0, retry_cnt_o=3; new start clears fail_o.
- Loss of lock: locked at period 1250, stb_i stops -> lock_o drops 2501 cycles after last edge, retry_cnt_o=1, RST re-entered.
- Tolerance boundary: intervals 1254 and 1246 lock; interval 1255 in CONFIRM triggers a retry.
- Abort and reset: abort_i during DETECT -> IDLE next cycle with stb_arst_o=1, busy_o=0. Simultaneous start_i+abort_i in IDLE -> remains IDLE. arst_ni low in LOCKED -> all outputs at reset values immediately.
